// File: rtl/comparator_arbiter_if.sv
// comparator_arbiter_if
//   Bundles the request/operand/result signals between the client FSMs and
//   the shared comparator arbiter.
//   Parameters: WIDTH (operand width), N (number of requesters).
//   Signals:
//     req      N        per-requester valid operands
//     a_in     N*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//     b_in     N*WIDTH  operand B, same packing
//     gnt      N        one-hot capture pulse
//     done     1        result valid pulse
//     done_id  IDW      requester index owning the result
//     gt/lt/eq 1        unsigned compare result of captured operands
//   Modports: master = requester side, slave = arbiter side.
interface comparator_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int N     = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] a_in;
  logic [N*WIDTH-1:0] b_in;
  logic [N-1:0]       gnt;
  logic               done;
  logic [IDW-1:0]     done_id;
  logic               gt;
  logic               lt;
  logic               eq;

  modport master (
    output req, a_in, b_in,
    input  gnt, done, done_id, gt, lt, eq
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, done, done_id, gt, lt, eq
  );
endinterface

// File: rtl/comparator_arbiter.sv
// comparator_arbiter
//   Shares one WIDTH-bit unsigned magnitude comparator between N requesters.
//   A winner is picked in IDLE, its operands captured and granted; the next
//   cycle registers gt/lt/eq with the winner's ID. One comparison per 2 clocks.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    comparator_arbiter_if.slave (req/a_in/b_in in, gnt/done/done_id/gt/lt/eq out)
//   Configuration macro:
//     CMP_ARB_FIXED_PRIO_EN  defined: lowest set req index always wins;
//                            undefined: round-robin starting after the last served ID.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | sample req; on any request capture winner's operands, pulse gnt
//   COMPARE | register gt/lt/eq and done_id, pulse done, update last
module comparator_arbiter #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  comparator_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(N);

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             done_q, done_d;
  logic [IDW-1:0]   done_id_q, done_id_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
`ifndef CMP_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]   last_q, last_d;
`endif

  logic [IDW-1:0]   win;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

`ifdef CMP_ARB_FIXED_PRIO_EN
  // Scan from the top down so the lowest set index is the one left in win.
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) win = IDW'(i);
    end
  end
`else
  // Search (last+1) .. (last+N) mod N; the first hit wins. last+1+k never
  // exceeds 2N-1, so a single subtraction implements the wrap.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    logic           found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(last_q) + 1 + k;
      if (idx >= N) idx = idx - N;
      cand = IDW'(idx);
      if (!found && bus.req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end
`endif

  // Constant-index mux avoids a variable part-select on the packed buses.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (win == IDW'(i)) begin
        sel_a = bus.a_in[i*WIDTH +: WIDTH];
        sel_b = bus.b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    id_d      = id_q;
    gnt_d     = '0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    eq_d      = eq_q;
`ifndef CMP_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          op_a_d  = sel_a;
          op_b_d  = sel_b;
          id_d    = win;
          gnt_d   = N'(1) << win;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        gt_d      = (op_a_q > op_b_q);
        lt_d      = (op_a_q < op_b_q);
        eq_d      = (op_a_q == op_b_q);
        done_id_d = id_q;
        done_d    = 1'b1;
`ifndef CMP_ARB_FIXED_PRIO_EN
        last_d    = id_q;
`endif
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      id_q      <= '0;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
`ifndef CMP_ARB_FIXED_PRIO_EN
      last_q    <= IDW'(N - 1);
`endif
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      id_q      <= id_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
      eq_q      <= eq_d;
`ifndef CMP_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.gt      = gt_q;
  assign bus.lt      = lt_q;
  assign bus.eq      = eq_q;

endmodule

// File: tb/tb_comparator_arbiter.sv
// tb_comparator_arbiter
//   Self-checking bench for comparator_arbiter (WIDTH=4, N=4). A slot-level
//   reference model predicts every output each cycle; directed sequences pin
//   the model with literal expectations; a randomized phase follows.
module tb_comparator_arbiter;
  localparam int WIDTH = 4;
  localparam int N     = 4;

  logic clk;
  logic rst_n;

  comparator_arbiter_if #(.WIDTH(WIDTH), .N(N)) bus ();

  comparator_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a slot is either free (next request starts one) or the
  // second half of a started comparison (result is produced).
  logic [N-1:0] exp_gnt;
  logic         exp_done;
  int           exp_id;
  logic         exp_gt, exp_lt, exp_eq;
  bit           m_busy;
  int           m_last;
  int           m_id;
  int           m_a, m_b;

  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef CMP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_gnt = '0; exp_done = 1'b0; exp_id = 0;
      exp_gt = 1'b0; exp_lt = 1'b0; exp_eq = 1'b0;
      m_busy = 1'b0; m_last = N - 1;
    end else if (m_busy) begin
      exp_gnt  = '0;
      exp_done = 1'b1;
      exp_id   = m_id;
      exp_gt   = (m_a > m_b);
      exp_lt   = (m_a < m_b);
      exp_eq   = (m_a == m_b);
      m_last   = m_id;
      m_busy   = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (bus.req != '0) begin
        m_id    = pick(bus.req, m_last);
        m_a     = int'((bus.a_in >> (m_id * WIDTH)) & 16'hF);
        m_b     = int'((bus.b_in >> (m_id * WIDTH)) & 16'hF);
        exp_gnt = '0;
        exp_gnt[m_id] = 1'b1;
        m_busy  = 1'b1;
      end else begin
        exp_gnt = '0;
      end
    end
    #1;
    check("m_gnt", 32'(bus.gnt), 32'(exp_gnt));
    check("m_done", 32'(bus.done), 32'(exp_done));
    check("m_result", {25'd0, bus.gt, bus.lt, bus.eq, 3'd0, bus.done_id},
          {25'd0, exp_gt, exp_lt, exp_eq, 3'd0, exp_id[1:0]});
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    bus.a_in[i*WIDTH +: WIDTH] = WIDTH'(a);
    bus.b_in[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  initial begin
    int ids[$];
    int exp_rr[8];
    int exp_p[8];
    int ndone;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    tick();
    tick();
    // reset values
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_flags", {29'd0, bus.gt, bus.lt, bus.eq}, 0);
    check("rst_id", 32'(bus.done_id), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_gnt", 32'(bus.gnt), 0);
    check("idle_done", 32'(bus.done), 0);

    // single request, A2=9 B2=3
    set_ops(2, 9, 3);
    bus.req = 4'b0100;
    tick();
    check("single_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    tick();
    check("single_done", 32'(bus.done), 1);
    check("single_id", 32'(bus.done_id), 2);
    check("single_gt", {29'd0, bus.gt, bus.lt, bus.eq}, 32'b100);

    // equal then less on requester 0
    set_ops(0, 5, 5);
    bus.req = 4'b0001;
    tick();
    check("eq_gnt", 32'(bus.gnt), 32'h1);
    set_ops(0, 0, 15);
    tick();
    check("eq_done", 32'(bus.done), 1);
    check("eq_flags", {29'd0, bus.gt, bus.lt, bus.eq}, 32'b001);
    tick();
    check("eq_pulse", 32'(bus.done), 0);
    check("lt_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    check("lt_flags", {28'd0, bus.done, bus.gt, bus.lt, bus.eq}, 32'b1010);
    tick();
    check("lt_pulse", 32'(bus.done), 0);
    check("lt_hold", {29'd0, bus.gt, bus.lt, bus.eq}, 32'b010);

    // all requesting from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.req = 4'b1111;
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef CMP_ARB_FIXED_PRIO_EN
    exp_rr = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
    ids.delete();
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.done) ids.push_back(int'(bus.done_id));
    end
    check("rr_count", 32'(ids.size()), 8);
    for (int i = 0; i < 8 && i < ids.size(); i++) check("rr_id", 32'(ids[i]), 32'(exp_rr[i]));

    // requesters 1 and 3 only
    bus.req = 4'b1010;
    exp_p = '{1, 3, 1, 3, 1, 3, 1, 3};
`ifdef CMP_ARB_FIXED_PRIO_EN
    exp_p = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
    ids.delete();
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.done) ids.push_back(int'(bus.done_id));
    end
    check("pair_count", 32'(ids.size()), 8);
    for (int i = 0; i < 8 && i < ids.size(); i++) check("pair_id", 32'(ids[i]), 32'(exp_p[i]));
    bus.req = '0;
    tick();
    tick();

    // reset during COMPARE
    set_ops(0, 7, 2);
    bus.req = 4'b0001;
    tick();
    check("abort_gnt", 32'(bus.gnt), 32'h1);
    rst_n = 1'b0;
    bus.req = '0;
    #1;
    check("abort_now", {30'd0, bus.done, |bus.gnt}, 0);
    tick();
    check("abort_nodone", 32'(bus.done), 0);
    rst_n = 1'b1;
    bus.req = 4'b0001;
    tick();
    check("post_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    tick();
    check("post_done", {28'd0, bus.done, bus.gt, bus.lt, bus.eq}, 32'b1100);

    // randomized traffic, occasional reset
    ndone = 0;
    for (int c = 0; c < 600; c++) begin
      bus.req  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      bus.a_in = (N*WIDTH)'($urandom());
      bus.b_in = ($urandom_range(0, 4) == 0) ? bus.a_in : (N*WIDTH)'($urandom());
      if ($urandom_range(0, 60) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      if (bus.done) ndone++;
    end
    bus.req = '0;
    tick();
    tick();
    if (ndone < 50) check("rand_activity", 32'(ndone), 50);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
